// File: rtl/accum_buffer_bank_pkg.sv
`default_nettype none
//==============================================================================
// Package  : accum_pkg -- shared types and arithmetic helpers for accum_buffer_bank
// Revision : 1.0
//==============================================================================
package accum_pkg;

   localparam int MAX_W = 64;

   typedef enum logic [0:0] {
      CLR_IDLE = 1'b0,
      CLR_RUN  = 1'b1
   } clr_state_e;

   // Widen an in_w-bit value held in the low bits of x; bits above in_w are ignored.
   function automatic logic [MAX_W-1:0] ext_in(input logic [MAX_W-1:0] x,
                                                input int               in_w,
                                                input logic             sgn);
      logic [MAX_W-1:0] hi_mask;
      logic             msb;
      hi_mask = ~((MAX_W'(1) << in_w) - MAX_W'(1));
      msb     = sgn & (|(x & (MAX_W'(1) << (in_w - 1))));
      return msb ? (x | hi_mask) : (x & ~hi_mask);
   endfunction

   // acc_w-bit two's complement add clamped to the signed range; upper bits are don't-care.
   function automatic logic [MAX_W-1:0] sat_add(input  logic [MAX_W-1:0] a,
                                                 input  logic [MAX_W-1:0] b,
                                                 input  int               acc_w,
                                                 output logic             sat);
      logic [MAX_W-1:0] s;
      logic [MAX_W-1:0] sign_bit;
      logic             sa, sb, ss;
      sign_bit = MAX_W'(1) << (acc_w - 1);
      s        = a + b;
      sa       = |(a & sign_bit);
      sb       = |(b & sign_bit);
      ss       = |(s & sign_bit);
      sat      = (sa == sb) && (ss != sa);
      if (sat) begin
         s = sa ? sign_bit : (sign_bit - MAX_W'(1));
      end
      return s;
   endfunction

endpackage : accum_pkg
`default_nettype wire

// File: rtl/accum_buffer_bank_lane.sv
`default_nettype none
//==============================================================================
// Module   : accum_lane -- one column's two buffers of DEPTH accumulator rows
// Revision : 1.0
//==============================================================================
module accum_lane
   import accum_pkg::*;
#(
   parameter  int IN_W      = 16,
   parameter  int ACC_W     = 32,
   parameter  int DEPTH     = 4,
   parameter  int IN_SIGNED = 1,
   localparam int AW        = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             wr_en,
   input  logic             wr_mode,
   input  logic             wr_buf,
   input  logic [AW-1:0]    wr_addr,
   input  logic [IN_W-1:0]  wr_data,
   input  logic             clr_en,
   input  logic             clr_buf,
   input  logic [AW-1:0]    clr_addr,
   input  logic             rd_buf,
   input  logic [AW-1:0]    rd_addr,
   output logic [ACC_W-1:0] old_row,
   output logic [ACC_W-1:0] new_row,
   output logic [ACC_W-1:0] rd_row
`ifdef ACCUM_SAT_EN
   ,
   output logic             sat_evt
`endif
);

   logic [ACC_W-1:0] r_mem [2][DEPTH];
   logic [ACC_W-1:0] w_ext;
   logic [ACC_W-1:0] w_sum;
`ifdef ACCUM_SAT_EN
   logic             w_sat;
`endif

   assign old_row = r_mem[wr_buf][wr_addr];
   assign rd_row  = r_mem[rd_buf][rd_addr];

   always_comb begin
      w_ext = ACC_W'(ext_in(MAX_W'(wr_data), IN_W, IN_SIGNED != 0));
`ifdef ACCUM_SAT_EN
      w_sum = ACC_W'(sat_add(MAX_W'(old_row), MAX_W'(w_ext), ACC_W, w_sat));
`else
      w_sum = old_row + w_ext;
`endif
      new_row = wr_mode ? w_sum : w_ext;
   end

`ifdef ACCUM_SAT_EN
   assign sat_evt = wr_en & wr_mode & w_sat;
`endif

   // The clear engine never targets the buffer being written, so the two updates never collide.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int b = 0; b < 2; b++) begin
            for (int r = 0; r < DEPTH; r++) begin
               r_mem[b][r] <= '0;
            end
         end
      end else begin
         if (wr_en) begin
            r_mem[wr_buf][wr_addr] <= new_row;
         end
         if (clr_en) begin
            r_mem[clr_buf][clr_addr] <= '0;
         end
      end
   end

endmodule : accum_lane
`default_nettype wire

// File: rtl/accum_buffer_bank.sv
`default_nettype none
//==============================================================================
// Module   : accum_buffer_bank -- double-buffered accumulator bank with clear engine;
//            define ACCUM_SAT_EN for saturating accumulate and the sat_flag port
// Revision : 1.0
//==============================================================================
module accum_buffer_bank
   import accum_pkg::*;
#(
   parameter  int NUM_COLS        = 2,
   parameter  int IN_W            = 16,
   parameter  int ACC_W           = 32,
   parameter  int DEPTH           = 4,
   parameter  int IN_SIGNED       = 1,
   parameter  int BYPASS_READ_NEW = 1,
   localparam int AW              = $clog2(DEPTH)
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      wr_valid,
   output logic                      wr_ready,
   input  logic                      wr_mode,
   input  logic                      wr_buf,
   input  logic [AW-1:0]             wr_addr,
   input  logic [NUM_COLS*IN_W-1:0]  wr_data,
   output logic                      wr_res_vld,
   output logic [NUM_COLS*ACC_W-1:0] wr_res,
   input  logic                      rd_en,
   input  logic                      rd_buf,
   input  logic [AW-1:0]             rd_addr,
   output logic                      rd_vld,
   output logic [NUM_COLS*ACC_W-1:0] rd_data,
   input  logic                      clr_start,
   input  logic                      clr_buf,
   output logic                      clr_busy
`ifdef ACCUM_SAT_EN
   ,
   output logic                      sat_flag
`endif
);

   clr_state_e                r_clr_state;
   logic                      r_clr_buf;
   logic [AW-1:0]             r_clr_ptr;
   logic                      w_accept;
   logic                      w_clr_en;
   logic [NUM_COLS*ACC_W-1:0] w_old;
   logic [NUM_COLS*ACC_W-1:0] w_new;
   logic [NUM_COLS*ACC_W-1:0] w_rd;
`ifdef ACCUM_SAT_EN
   logic [NUM_COLS-1:0]       w_sat_evt;
   logic                      r_sat_flag;
`endif

   assign w_clr_en = (r_clr_state == CLR_RUN);
   assign wr_ready = !w_clr_en || (wr_buf != r_clr_buf);
   assign w_accept = wr_valid && wr_ready;
   assign clr_busy = w_clr_en;

   for (genvar c = 0; c < NUM_COLS; c++) begin : g_lane
      accum_lane #(
         .IN_W      (IN_W),
         .ACC_W     (ACC_W),
         .DEPTH     (DEPTH),
         .IN_SIGNED (IN_SIGNED)
      ) u_lane (
         .clk      (clk),
         .reset    (reset),
         .wr_en    (w_accept),
         .wr_mode  (wr_mode),
         .wr_buf   (wr_buf),
         .wr_addr  (wr_addr),
         .wr_data  (wr_data[c*IN_W +: IN_W]),
         .clr_en   (w_clr_en),
         .clr_buf  (r_clr_buf),
         .clr_addr (r_clr_ptr),
         .rd_buf   (rd_buf),
         .rd_addr  (rd_addr),
         .old_row  (w_old[c*ACC_W +: ACC_W]),
         .new_row  (w_new[c*ACC_W +: ACC_W]),
         .rd_row   (w_rd[c*ACC_W +: ACC_W])
`ifdef ACCUM_SAT_EN
         ,
         .sat_evt  (w_sat_evt[c])
`endif
      );
   end

   // A clr_start arriving with a same-buffer write lets that write land first; the clear begins next cycle.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_clr_state <= CLR_IDLE;
         r_clr_buf   <= 1'b0;
         r_clr_ptr   <= '0;
      end else begin
         case (r_clr_state)
            CLR_IDLE: begin
               if (clr_start) begin
                  r_clr_state <= CLR_RUN;
                  r_clr_buf   <= clr_buf;
                  r_clr_ptr   <= '0;
               end
            end
            CLR_RUN: begin
               if (r_clr_ptr == AW'(DEPTH - 1)) begin
                  r_clr_state <= CLR_IDLE;
                  r_clr_ptr   <= '0;
               end else begin
                  r_clr_ptr <= r_clr_ptr + 1'b1;
               end
            end
            default: r_clr_state <= CLR_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_res_vld <= 1'b0;
         wr_res     <= '0;
         rd_vld     <= 1'b0;
         rd_data    <= '0;
      end else begin
         wr_res_vld <= w_accept;
         if (w_accept) begin
            wr_res <= (BYPASS_READ_NEW != 0) ? w_new : w_old;
         end
         rd_vld <= rd_en;
         if (rd_en) begin
            rd_data <= w_rd;
         end
      end
   end

`ifdef ACCUM_SAT_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_sat_flag <= 1'b0;
      end else begin
         r_sat_flag <= r_sat_flag | (|w_sat_evt);
      end
   end
   assign sat_flag = r_sat_flag;
`endif

endmodule : accum_buffer_bank
`default_nettype wire

// File: tb/tb_accum_buffer_bank.sv
`default_nettype none
//==============================================================================
// Module   : tb_accum_buffer_bank -- three configurations driven in lockstep against a reference model
// Revision : 1.0
//==============================================================================
module tb_accum_buffer_bank;

   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic        wr_valid, wr_mode, wr_buf, rd_en, rd_buf, clr_start, clr_buf;
   logic [1:0]  wr_addr, rd_addr;
   logic [31:0] wr_data;

   logic [2:0]  rdy, res_vld, rvld, busy;
   logic [2:0]  sat;
   logic [63:0] res_a, res_b, rd_a, rd_b;
   logic [35:0] res_n, rd_n;

   // Instance 0: signed 32b post-write result, 1: unsigned 32b pre-write result, 2: signed 18b.
   int  W  [3] = '{32, 32, 18};
   bit  SG [3] = '{1'b1, 1'b0, 1'b1};
   bit  BY [3] = '{1'b1, 1'b0, 1'b1};

   longint m      [3][2][DEPTH][2];
   bit     m_sat  [3];
   bit     m_busy;
   bit     m_cbuf;
   int     m_cptr;
   longint e_res  [3][2];
   longint e_rd   [3][2];
   bit     e_acc, e_busy;

   int n_checks;
   int n_errors;

   always #5 clk = ~clk;

   accum_buffer_bank #(.NUM_COLS(2), .IN_W(16), .ACC_W(32), .DEPTH(4), .IN_SIGNED(1), .BYPASS_READ_NEW(1)) u_dut_a (
      .clk(clk), .reset(reset), .wr_valid(wr_valid), .wr_ready(rdy[0]), .wr_mode(wr_mode),
      .wr_buf(wr_buf), .wr_addr(wr_addr), .wr_data(wr_data), .wr_res_vld(res_vld[0]), .wr_res(res_a),
      .rd_en(rd_en), .rd_buf(rd_buf), .rd_addr(rd_addr), .rd_vld(rvld[0]), .rd_data(rd_a),
      .clr_start(clr_start), .clr_buf(clr_buf), .clr_busy(busy[0])
`ifdef ACCUM_SAT_EN
      , .sat_flag(sat[0])
`endif
   );

   accum_buffer_bank #(.NUM_COLS(2), .IN_W(16), .ACC_W(32), .DEPTH(4), .IN_SIGNED(0), .BYPASS_READ_NEW(0)) u_dut_b (
      .clk(clk), .reset(reset), .wr_valid(wr_valid), .wr_ready(rdy[1]), .wr_mode(wr_mode),
      .wr_buf(wr_buf), .wr_addr(wr_addr), .wr_data(wr_data), .wr_res_vld(res_vld[1]), .wr_res(res_b),
      .rd_en(rd_en), .rd_buf(rd_buf), .rd_addr(rd_addr), .rd_vld(rvld[1]), .rd_data(rd_b),
      .clr_start(clr_start), .clr_buf(clr_buf), .clr_busy(busy[1])
`ifdef ACCUM_SAT_EN
      , .sat_flag(sat[1])
`endif
   );

   accum_buffer_bank #(.NUM_COLS(2), .IN_W(16), .ACC_W(18), .DEPTH(4), .IN_SIGNED(1), .BYPASS_READ_NEW(1)) u_dut_n (
      .clk(clk), .reset(reset), .wr_valid(wr_valid), .wr_ready(rdy[2]), .wr_mode(wr_mode),
      .wr_buf(wr_buf), .wr_addr(wr_addr), .wr_data(wr_data), .wr_res_vld(res_vld[2]), .wr_res(res_n),
      .rd_en(rd_en), .rd_buf(rd_buf), .rd_addr(rd_addr), .rd_vld(rvld[2]), .rd_data(rd_n),
      .clr_start(clr_start), .clr_buf(clr_buf), .clr_busy(busy[2])
`ifdef ACCUM_SAT_EN
      , .sat_flag(sat[2])
`endif
   );

`ifndef ACCUM_SAT_EN
   assign sat = 3'b000;
`endif

   // ---------------- reference model ----------------
   function automatic longint mask(longint v, int w);
      return v & ((longint'(1) << w) - 1);
   endfunction

   function automatic longint sx(longint v, int w);
      if (((v >> (w - 1)) & 1) != 0) return v - (longint'(1) << w);
      return v;
   endfunction

   function automatic longint ext16(logic [15:0] d, bit sg, int w);
      longint v;
      v = sg ? longint'($signed(d)) : longint'(d);
      return mask(v, w);
   endfunction

   function automatic longint model_add(longint a, longint b, int w, output bit s_evt);
      longint s;
      s     = sx(a, w) + sx(b, w);
      s_evt = 1'b0;
`ifdef ACCUM_SAT_EN
      if (s > (longint'(1) << (w - 1)) - 1) begin
         s     = (longint'(1) << (w - 1)) - 1;
         s_evt = 1'b1;
      end
      if (s < -(longint'(1) << (w - 1))) begin
         s     = -(longint'(1) << (w - 1));
         s_evt = 1'b1;
      end
`endif
      return mask(s, w);
   endfunction

   function automatic longint get_res(int i, int c);
      case (i)
         0:       return longint'(res_a[c*32 +: 32]);
         1:       return longint'(res_b[c*32 +: 32]);
         default: return longint'(res_n[c*18 +: 18]);
      endcase
   endfunction

   function automatic longint get_rd(int i, int c);
      case (i)
         0:       return longint'(rd_a[c*32 +: 32]);
         1:       return longint'(rd_b[c*32 +: 32]);
         default: return longint'(rd_n[c*18 +: 18]);
      endcase
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 3; i++) begin
         m_sat[i] = 1'b0;
         for (int c = 0; c < 2; c++) begin
            e_res[i][c] = 0;
            e_rd[i][c]  = 0;
            for (int b = 0; b < 2; b++)
               for (int r = 0; r < DEPTH; r++) m[i][b][r][c] = 0;
         end
      end
      m_busy = 1'b0;
      m_cbuf = 1'b0;
      m_cptr = 0;
   endtask

   task automatic idle_inputs();
      wr_valid = 1'b0; wr_mode = 1'b0; wr_buf = 1'b0; wr_addr = 2'd0; wr_data = 32'd0;
      rd_en = 1'b0; rd_buf = 1'b0; rd_addr = 2'd0; clr_start = 1'b0; clr_buf = 1'b0;
   endtask

   // Advance the model by one clock using the current inputs, then clock the DUTs and settle.
   task automatic tick();
      longint old_v, x_v, n_v;
      bit     se;
      e_acc = wr_valid && (!m_busy || (wr_buf != m_cbuf));
      for (int i = 0; i < 3; i++) begin
         for (int c = 0; c < 2; c++) begin
            if (rd_en) e_rd[i][c] = m[i][rd_buf][rd_addr][c];
            old_v = m[i][wr_buf][wr_addr][c];
            x_v   = ext16(wr_data[c*16 +: 16], SG[i], W[i]);
            se    = 1'b0;
            n_v   = wr_mode ? model_add(old_v, x_v, W[i], se) : x_v;
            if (e_acc) begin
               e_res[i][c] = BY[i] ? n_v : old_v;
               m[i][wr_buf][wr_addr][c] = n_v;
               if (se) m_sat[i] = 1'b1;
            end
         end
      end
      if (m_busy) begin
         for (int i = 0; i < 3; i++)
            for (int c = 0; c < 2; c++) m[i][m_cbuf][m_cptr][c] = 0;
         if (m_cptr == DEPTH - 1) m_busy = 1'b0;
         else m_cptr++;
      end else if (clr_start) begin
         m_busy = 1'b1;
         m_cbuf = clr_buf;
         m_cptr = 0;
      end
      e_busy = m_busy;
      @(posedge clk);
      #1;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      reset = 1'b1;
      idle_inputs();
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      n_checks++;
      if (rdy !== 3'b111 || res_vld !== 3'b000 || rvld !== 3'b000 || busy !== 3'b000) begin
         n_errors++;
         $display("FAIL reset_ctrl: got rdy=%b res_vld=%b rd_vld=%b busy=%b expected 111 000 000 000", rdy, res_vld, rvld, busy);
      end
      n_checks++;
      if (res_a !== 64'd0 || res_b !== 64'd0 || res_n !== 36'd0 || rd_a !== 64'd0 || rd_b !== 64'd0 || rd_n !== 36'd0) begin
         n_errors++;
         $display("FAIL reset_data: got res_a=%h rd_a=%h res_n=%h rd_n=%h expected all zero", res_a, rd_a, res_n, rd_n);
      end
      @(negedge clk);
      reset = 1'b0;
      for (int k = 0; k < 2 * DEPTH; k++) begin
         @(negedge clk);
         idle_inputs();
         rd_en = 1'b1; rd_buf = k[2]; rd_addr = k[1:0];
         tick();
         n_checks++;
         if (rvld !== 3'b111 || rd_a !== 64'd0 || rd_b !== 64'd0 || rd_n !== 36'd0) begin
            n_errors++;
            $display("FAIL reset_rows: row %0d got vld=%b a=%h b=%h n=%h expected 111 and zero", k, rvld, rd_a, rd_b, rd_n);
         end
      end
   endtask

   task automatic test_basic();
      @(negedge clk);
      idle_inputs();
      wr_valid = 1'b1; wr_mode = 1'b0; wr_buf = 1'b0; wr_addr = 2'd1; wr_data = {16'hFFFD, 16'h0005};
      tick();
      @(negedge clk);
      wr_mode = 1'b1; wr_data = {16'hFFFE, 16'h000A};
      tick();
      n_checks++;
      if (res_vld !== 3'b111 || res_a !== {32'hFFFF_FFFB, 32'h0000_000F}) begin
         n_errors++;
         $display("FAIL accum_post: got vld=%b res=%h expected 111 fffffffb0000000f", res_vld, res_a);
      end
      n_checks++;
      if (res_b !== {32'h0000_FFFD, 32'h0000_0005}) begin
         n_errors++;
         $display("FAIL accum_pre: got res=%h expected 0000fffd00000005", res_b);
      end
      @(negedge clk);
      idle_inputs();
      rd_en = 1'b1; rd_buf = 1'b0; rd_addr = 2'd1;
      tick();
      n_checks++;
      if (res_vld !== 3'b000) begin
         n_errors++;
         $display("FAIL res_vld_pulse: got %b expected 000", res_vld);
      end
      n_checks++;
      if (rvld !== 3'b111 || rd_a !== {32'hFFFF_FFFB, 32'h0000_000F} || rd_b !== {32'h0001_FFFB, 32'h0000_000F}) begin
         n_errors++;
         $display("FAIL accum_read: got vld=%b a=%h b=%h expected 111 fffffffb0000000f 0001fffb0000000f", rvld, rd_a, rd_b);
      end
   endtask

   task automatic test_unsigned();
      @(negedge clk);
      idle_inputs();
      wr_valid = 1'b1; wr_buf = 1'b0; wr_addr = 2'd2; wr_data = 32'hFFFF_FFFF;
      tick();
      @(negedge clk);
      idle_inputs();
      rd_en = 1'b1; rd_buf = 1'b0; rd_addr = 2'd2;
      tick();
      n_checks++;
      if (rd_b !== {2{32'h0000_FFFF}} || rd_a !== {2{32'hFFFF_FFFF}}) begin
         n_errors++;
         $display("FAIL extension: got unsigned=%h signed=%h expected 0000ffff0000ffff ffffffffffffffff", rd_b, rd_a);
      end
   endtask

   task automatic test_back_to_back();
      for (int k = 0; k < DEPTH; k++) begin
         @(negedge clk);
         idle_inputs();
         wr_valid = 1'b1; wr_mode = 1'($urandom_range(0, 1)); wr_buf = 1'b1; wr_addr = k[1:0]; wr_data = $urandom;
         rd_en = 1'b1; rd_buf = 1'b0; rd_addr = k[1:0];
         tick();
         for (int i = 0; i < 3; i++) begin
            for (int c = 0; c < 2; c++) begin
               n_checks++;
               if (rvld[i] !== 1'b1 || get_rd(i, c) !== e_rd[i][c] || res_vld[i] !== 1'b1 || get_res(i, c) !== e_res[i][c]) begin
                  n_errors++;
                  $display("FAIL b2b: inst %0d row %0d col %0d got vld=%b rd=%h res=%h expected 1 %h %h",
                           i, k, c, rvld[i], get_rd(i, c), get_res(i, c), e_rd[i][c], e_res[i][c]);
               end
            end
         end
      end
      @(negedge clk);
      idle_inputs();
      tick();
      n_checks++;
      if (rvld !== 3'b000 || get_rd(0, 0) !== e_rd[0][0] || get_rd(2, 1) !== e_rd[2][1]) begin
         n_errors++;
         $display("FAIL rd_hold: got vld=%b rd_a=%h expected 000 and held data", rvld, rd_a);
      end
   endtask

   task automatic test_clear();
      int busy_cycles;
      @(negedge clk);
      idle_inputs();
      wr_valid = 1'b1; wr_buf = 1'b0; wr_addr = 2'd3; wr_data = 32'h0042_0077;
      tick();
      @(negedge clk);
      idle_inputs();
      clr_start = 1'b1; clr_buf = 1'b0;
      tick();
      busy_cycles = (busy[0] === 1'b1) ? 1 : 0;
      for (int k = 0; k < 10 && busy[0] === 1'b1; k++) begin
         @(negedge clk);
         idle_inputs();
         clr_start = 1'b1; clr_buf = 1'b1;
         wr_valid = 1'b1; wr_buf = k[0]; wr_addr = k[1:0]; wr_data = $urandom;
         #1;
         n_checks++;
         if (rdy !== (k[0] ? 3'b111 : 3'b000)) begin
            n_errors++;
            $display("FAIL clr_ready: step %0d buf %0d got %b expected %b", k, k[0], rdy, k[0] ? 3'b111 : 3'b000);
         end
         tick();
         n_checks++;
         if (res_vld !== {3{e_acc}} || busy !== {3{e_busy}}) begin
            n_errors++;
            $display("FAIL clr_step: step %0d got vld=%b busy=%b expected %b %b", k, res_vld, busy, {3{e_acc}}, {3{e_busy}});
         end
         if (busy[0] === 1'b1) busy_cycles++;
      end
      n_checks++;
      if (busy_cycles != DEPTH) begin
         n_errors++;
         $display("FAIL clr_len: got %0d busy cycles expected %0d", busy_cycles, DEPTH);
      end
      for (int r = 0; r < DEPTH; r++) begin
         @(negedge clk);
         idle_inputs();
         rd_en = 1'b1; rd_buf = 1'b0; rd_addr = r[1:0];
         tick();
         n_checks++;
         if (rd_a !== 64'd0 || rd_b !== 64'd0 || rd_n !== 36'd0) begin
            n_errors++;
            $display("FAIL clr_rows: row %0d got a=%h b=%h n=%h expected zero", r, rd_a, rd_b, rd_n);
         end
      end
   endtask

   task automatic test_clear_same_cycle();
      @(negedge clk);
      idle_inputs();
      wr_valid = 1'b1; wr_buf = 1'b1; wr_addr = 2'd3; wr_data = 32'h1234_5678;
      clr_start = 1'b1; clr_buf = 1'b1;
      #1;
      n_checks++;
      if (rdy !== 3'b111) begin
         n_errors++;
         $display("FAIL clr_start_ready: got %b expected 111", rdy);
      end
      tick();
      n_checks++;
      if (res_vld !== 3'b111 || res_a !== {32'h0000_1234, 32'h0000_5678} || busy !== 3'b111) begin
         n_errors++;
         $display("FAIL clr_start_write: got vld=%b res=%h busy=%b expected 111 0000123400005678 111", res_vld, res_a, busy);
      end
      for (int k = 0; k < 8 && busy[0] === 1'b1; k++) begin
         @(negedge clk);
         idle_inputs();
         tick();
      end
      @(negedge clk);
      idle_inputs();
      rd_en = 1'b1; rd_buf = 1'b1; rd_addr = 2'd3;
      tick();
      n_checks++;
      if (busy !== 3'b000 || rd_a !== 64'd0 || rd_n !== 36'd0) begin
         n_errors++;
         $display("FAIL clr_after_write: got busy=%b rd_a=%h rd_n=%h expected 000 zero zero", busy, rd_a, rd_n);
      end
   endtask

   task automatic test_same_cycle();
      @(negedge clk);
      idle_inputs();
      wr_valid = 1'b1; wr_buf = 1'b1; wr_addr = 2'd2; wr_data = 32'h0007_0007;
      tick();
      @(negedge clk);
      wr_mode = 1'b1; wr_data = 32'h0001_0001;
      rd_en = 1'b1; rd_buf = 1'b1; rd_addr = 2'd2;
      tick();
      n_checks++;
      if (rd_a !== {2{32'd7}} || res_a !== {2{32'd8}}) begin
         n_errors++;
         $display("FAIL no_forward: got rd=%h res=%h expected 0000000700000007 0000000800000008", rd_a, res_a);
      end
      @(negedge clk);
      idle_inputs();
      rd_en = 1'b1; rd_buf = 1'b1; rd_addr = 2'd2;
      tick();
      n_checks++;
      if (rd_a !== {2{32'd8}} || rd_n !== {2{18'd8}}) begin
         n_errors++;
         $display("FAIL after_forward: got a=%h n=%h expected 0000000800000008 and 8", rd_a, rd_n);
      end
   endtask

   task automatic test_sat();
      @(negedge clk);
      idle_inputs();
      wr_valid = 1'b1; wr_buf = 1'b0; wr_addr = 2'd3; wr_data = 32'h7FFF_7FFF;
      tick();
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         wr_mode = 1'b1;
         wr_data = (k < 3) ? 32'h7FFF_7FFF : 32'h0100_0100;
         tick();
      end
      @(negedge clk);
      idle_inputs();
      rd_en = 1'b1; rd_buf = 1'b0; rd_addr = 2'd3;
      tick();
      n_checks++;
      if (rd_a !== {2{32'h0002_00FC}}) begin
         n_errors++;
         $display("FAIL wide_no_ovf: got %h expected 000200fc000200fc", rd_a);
      end
`ifdef ACCUM_SAT_EN
      n_checks++;
      if (rd_n !== {2{18'h1FFFF}} || sat !== 3'b100) begin
         n_errors++;
         $display("FAIL saturate: got row=%h sat=%b expected %h 100", rd_n, sat, {2{18'h1FFFF}});
      end
      repeat (3) begin
         @(negedge clk);
         idle_inputs();
         tick();
      end
      n_checks++;
      if (sat !== 3'b100) begin
         n_errors++;
         $display("FAIL sat_sticky: got %b expected 100", sat);
      end
`else
      n_checks++;
      if (rd_n !== {2{18'h200FC}}) begin
         n_errors++;
         $display("FAIL wrap: got row=%h expected %h", rd_n, {2{18'h200FC}});
      end
`endif
   endtask

   task automatic test_random();
      bit exp_rdy;
      for (int n = 0; n < 400; n++) begin
         @(negedge clk);
         wr_valid  = 1'($urandom_range(0, 1));
         wr_mode   = 1'($urandom_range(0, 1));
         wr_buf    = 1'($urandom_range(0, 1));
         wr_addr   = 2'($urandom_range(0, 3));
         wr_data   = $urandom;
         rd_en     = 1'($urandom_range(0, 1));
         rd_buf    = 1'($urandom_range(0, 1));
         rd_addr   = 2'($urandom_range(0, 3));
         clr_start = ($urandom_range(0, 15) == 0);
         clr_buf   = 1'($urandom_range(0, 1));
         #1;
         exp_rdy = !m_busy || (wr_buf != m_cbuf);
         n_checks++;
         if (rdy !== {3{exp_rdy}}) begin
            n_errors++;
            $display("FAIL rnd_ready: cycle %0d got %b expected %b", n, rdy, {3{exp_rdy}});
         end
         tick();
         n_checks++;
         if (res_vld !== {3{e_acc}} || rvld !== {3{rd_en}} || busy !== {3{e_busy}}) begin
            n_errors++;
            $display("FAIL rnd_ctrl: cycle %0d got vld=%b rvld=%b busy=%b expected %b %b %b",
                     n, res_vld, rvld, busy, {3{e_acc}}, {3{rd_en}}, {3{e_busy}});
         end
         for (int i = 0; i < 3; i++) begin
            for (int c = 0; c < 2; c++) begin
               n_checks++;
               if (get_rd(i, c) !== e_rd[i][c] || (e_acc && get_res(i, c) !== e_res[i][c])) begin
                  n_errors++;
                  $display("FAIL rnd_data: cycle %0d inst %0d col %0d got rd=%h res=%h expected %h %h",
                           n, i, c, get_rd(i, c), get_res(i, c), e_rd[i][c], e_res[i][c]);
               end
            end
`ifdef ACCUM_SAT_EN
            n_checks++;
            if (sat[i] !== m_sat[i]) begin
               n_errors++;
               $display("FAIL rnd_sat: cycle %0d inst %0d got %b expected %b", n, i, sat[i], m_sat[i]);
            end
`endif
         end
      end
   endtask

   task automatic test_reset_mid_clear();
      @(negedge clk);
      idle_inputs();
      wr_valid = 1'b1; wr_buf = 1'b0; wr_addr = 2'd1; wr_data = 32'h0033_0044;
      tick();
      @(negedge clk);
      wr_buf = 1'b1; wr_addr = 2'd2; wr_data = 32'h0055_0066;
      clr_start = 1'b1; clr_buf = 1'b0;
      tick();
      @(negedge clk);
      idle_inputs();
      tick();
      #2;
      reset = 1'b1;
      #1;
      n_checks++;
      if (busy !== 3'b000 || rdy !== 3'b111 || res_vld !== 3'b000 || rvld !== 3'b000) begin
         n_errors++;
         $display("FAIL reset_mid_clear: got busy=%b rdy=%b vld=%b rvld=%b expected 000 111 000 000", busy, rdy, res_vld, rvld);
      end
      model_reset();
      @(negedge clk);
      reset = 1'b0;
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         idle_inputs();
         rd_en = 1'b1; rd_buf = k[0]; rd_addr = k[0] ? 2'd2 : 2'd1;
         tick();
         n_checks++;
         if (rd_a !== 64'd0 || rd_b !== 64'd0 || rd_n !== 36'd0 || sat !== 3'b000) begin
            n_errors++;
            $display("FAIL reset_rows_after_clear: read %0d got a=%h b=%h n=%h sat=%b expected zero", k, rd_a, rd_b, rd_n, sat);
         end
      end
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      test_reset();
      test_basic();
      test_unsigned();
      test_back_to_back();
      test_clear();
      test_clear_same_cycle();
      test_same_cycle();
      test_sat();
      test_random();
      test_reset_mid_clear();
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no completion by 200000 time units expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule : tb_accum_buffer_bank
`default_nettype wire
